wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the register data width.
REQ-002 SHALL have parameter REG_NUM_BIT, default 5, meaning the register index width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  producer presents a writeback result.
REQ-007 in_ready  output  1  queue accepts a result this cycle.
REQ-008 in_rd  input  REG_NUM_BIT  destination register index.
REQ-009 in_data  input  DATA_WIDTH  result value.
REQ-010 rf_wen  output  1  register-file write enable.
REQ-011 rf_waddr  output  REG_NUM_BIT  register-file write index.
REQ-012 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-013 qaddr_a, qaddr_b  input  REG_NUM_BIT  hazard query indices (rs1, rs2).
REQ-014 hit_a, hit_b  output  1  a queued write targets the queried index.
REQ-015 fwd_a, fwd_b  output  DATA_WIDTH  data of the youngest matching queued entry.

Function
REQ-016 A handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 exactly when the entry count is less than DEPTH and rst=0; a same-cycle pop SHALL NOT raise in_ready.
REQ-018 A handshake with in_rd=0 SHALL be consumed and discarded, with no entry allocated.
REQ-019 A handshake with in_rd!=0 SHALL push {in_rd, in_data} at the tail.
REQ-020 rf_wen SHALL equal "count!=0"; rf_waddr and rf_wdata SHALL equal the head entry, and SHALL be 0 when the queue is empty.
REQ-021 The head SHALL pop on every edge where count!=0, giving one register-file write per cycle with no backpressure.
REQ-022 Latency SHALL be: result accepted at edge N is driven on rf_* during cycle N+1 and written at edge N+1, when the queue was empty.
REQ-023 Writes SHALL leave in acceptance order; two entries to the same rd SHALL both be written, older first.
REQ-024 A simultaneous push and pop SHALL leave the count unchanged.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-026 The count SHALL range 0..DEPTH and never overflow or underflow.
REQ-027 hit_x SHALL be 1 when qaddr_x!=0 and any valid entry, including the head being written this cycle, has rd==qaddr_x; the query is combinational.
REQ-028 fwd_x SHALL be the data of the youngest matching entry when hit_x=1, and 0 otherwise.
REQ-029 Querying index 0 SHALL always return hit=0 and fwd=0.
REQ-030 The same-cycle incoming in_data SHALL NOT be visible to the query.

Reset
REQ-031 While rst=1, the count, head and tail SHALL be cleared on each edge; all pending entries are lost.
REQ-032 While rst=1, in_ready SHALL be 0; a handshake attempted during reset SHALL be dropped.
REQ-033 After the reset edge: rf_wen=0, rf_waddr=0, rf_wdata=0, hit_a=hit_b=0, fwd_a=fwd_b=0, and in_ready=1 in the first cycle with rst=0.
REQ-034 Entry storage contents need no reset; valid state SHALL be derived only from the pointers and count.

Structure
REQ-035 DATA_WIDTH and REG_NUM_BIT defaults SHALL come from the shared NPC constants header, also used by the register file.
REQ-036 The FIFO storage, pointers and count SHALL be one sub-module, wb_fifo, exposing per-entry valid/rd/data for the match logic.
REQ-037 The youngest-match priority select SHALL live in wb_queue, ordered from the tail backwards.

Verification
REQ-038 Single push rd=5, data=0xDEADBEEF into an empty queue -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_wen=0.
REQ-039 Push rd=0, data=0x1234 -> in_ready=1, rf_wen stays 0, hit_a=0 for qaddr_a=0.
REQ-040 Hold pops stalled impossible; instead push 4 entries back-to-back with DEPTH=4 and in_valid held -> count never exceeds 4, and in_ready drops only when count=4 without a pop in flight; all 4 writes emerge in order.
REQ-041 Push rd=7/0x11, then rd=7/0x22; query qaddr_a=7 while both are queued -> hit_a=1, fwd_a=0x22; after both pop, hit_a=0.
REQ-042 Queue 3 entries, assert rst for one cycle -> the next cycle rf_wen=0, hit_b=0, in_ready=1, and no queued write reaches the register file.
REQ-043 Random push/query stream against a reference scoreboard -> register-file write sequence and fwd values match exactly over 10,000 cycles.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// Shared NPC constants for the writeback path.
// Supplies default data/index widths used by the register file and wb_queue.
package wb_queue_pkg;

  localparam int NPC_DATA_WIDTH  = 32;
  localparam int NPC_REG_NUM_BIT = 5;
  localparam int WB_DEPTH        = 4;

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: entry storage, head/tail pointers and occupancy count.
// Ports: clk, rst, push/pop + push_rd/push_data in; count, head, tail,
// per-entry ent_valid/ent_rd/ent_data (flattened) out for match logic.
module wb_fifo
  import wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH  = NPC_DATA_WIDTH,
  parameter int REG_NUM_BIT = NPC_REG_NUM_BIT,
  parameter int DEPTH       = WB_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [REG_NUM_BIT-1:0]       push_rd,
  input  logic [DATA_WIDTH-1:0]        push_data,
  output logic [CNT_W-1:0]             count,
  output logic [PTR_W-1:0]             head,
  output logic [PTR_W-1:0]             tail,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH*REG_NUM_BIT-1:0] ent_rd,
  output logic [DEPTH*DATA_WIDTH-1:0]  ent_data
);

  logic [REG_NUM_BIT-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]  data_q [DEPTH];
  logic                   push_ok;
  logic                   pop_ok;

  assign push_ok = push && (count < CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_q[tail]   <= push_rd;
      data_q[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot i is live when its distance from head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off = PTR_W'(i) - head;
    assign ent_valid[i] = {1'b0, off} < count;
    assign ent_rd[i*REG_NUM_BIT +: REG_NUM_BIT] = rd_q[i];
    assign ent_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers results, drains one RF write per cycle,
// and answers rs1/rs2 hazard queries with youngest-match forwarding.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH  = NPC_DATA_WIDTH,
  parameter int REG_NUM_BIT = NPC_REG_NUM_BIT,
  parameter int DEPTH       = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_NUM_BIT-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  input  logic [REG_NUM_BIT-1:0] qaddr_a,
  input  logic [REG_NUM_BIT-1:0] qaddr_b,
  output logic                   hit_a,
  output logic                   hit_b,
  output logic [DATA_WIDTH-1:0]  fwd_a,
  output logic [DATA_WIDTH-1:0]  fwd_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]             count;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH*REG_NUM_BIT-1:0] ent_rd;
  logic [DEPTH*DATA_WIDTH-1:0]  ent_data;
  logic                         push;
  logic                         pop;

  logic [REG_NUM_BIT-1:0] e_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]  e_data [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign e_rd[i]   = ent_rd[i*REG_NUM_BIT +: REG_NUM_BIT];
    assign e_data[i] = ent_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Ready reflects occupancy before this edge's pop.
  assign in_ready = !rst && (count < CNT_W'(DEPTH));
  // Writes to x0 are swallowed without taking a slot.
  assign push     = in_valid && in_ready && (in_rd != '0);
  assign pop      = count != '0;

  assign rf_wen   = pop;
  assign rf_waddr = pop ? e_rd[head]   : '0;
  assign rf_wdata = pop ? e_data[head] : '0;

  wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM_BIT(REG_NUM_BIT),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_rd  (in_rd),
    .push_data(in_data),
    .count    (count),
    .head     (head),
    .tail     (tail),
    .ent_valid(ent_valid),
    .ent_rd   (ent_rd),
    .ent_data (ent_data)
  );

  logic [REG_NUM_BIT-1:0] qaddr [2];
  logic                   hit   [2];
  logic [DATA_WIDTH-1:0]  fwd   [2];

  assign qaddr[0] = qaddr_a;
  assign qaddr[1] = qaddr_b;

  // Walk from the newest slot (tail-1) back to the oldest;
  // the first live match is the youngest write to that register.
  for (genvar p = 0; p < 2; p++) begin : g_query
    logic [PTR_W-1:0] idx;
    always_comb begin
      hit[p] = 1'b0;
      fwd[p] = '0;
      idx    = '0;
      for (int k = 1; k <= DEPTH; k++) begin
        idx = tail - PTR_W'(k);
        if (!hit[p] && qaddr[p] != '0 && ent_valid[idx] &&
            e_rd[idx] == qaddr[p]) begin
          hit[p] = 1'b1;
          fwd[p] = e_data[idx];
        end
      end
    end
  end

  assign hit_a = hit[0];
  assign hit_b = hit[1];
  assign fwd_a = fwd[0];
  assign fwd_b = fwd[1];

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed steps plus a random stream
// compared every cycle against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  qaddr_a;
  logic [4:0]  qaddr_b;
  logic        hit_a;
  logic        hit_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];

  always #5 clk = ~clk;

  wb_queue #(
    .DATA_WIDTH (32),
    .REG_NUM_BIT(5),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rd   (in_rd),
    .in_data (in_data),
    .rf_wen  (rf_wen),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .qaddr_a (qaddr_a),
    .qaddr_b (qaddr_b),
    .hit_a   (hit_a),
    .hit_b   (hit_b),
    .fwd_a   (fwd_a),
    .fwd_b   (fwd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void mquery(input logic [4:0] a, output logic h,
                                 output logic [31:0] f);
    h = 1'b0;
    f = '0;
    if (a != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == a) begin
          h = 1'b1;
          f = mq[i].d;
          break;
        end
      end
    end
  endfunction

  task automatic drive(input logic r, input logic v, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] qa,
                       input logic [4:0] qb);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    qaddr_a  = qa;
    qaddr_b  = qb;
    #1;
  endtask

  task automatic check_model();
    logic        h;
    logic [31:0] f;
    logic        ne;
    ne = mq.size() != 0;
    chk("in_ready", 32'(in_ready), 32'(!rst && mq.size() < DEPTH));
    chk("rf_wen", 32'(rf_wen), 32'(ne));
    chk("rf_waddr", 32'(rf_waddr), ne ? 32'(mq[0].rd) : 32'd0);
    chk("rf_wdata", rf_wdata, ne ? mq[0].d : 32'd0);
    mquery(qaddr_a, h, f);
    chk("hit_a", 32'(hit_a), 32'(h));
    chk("fwd_a", fwd_a, f);
    mquery(qaddr_b, h, f);
    chk("hit_b", 32'(hit_b), 32'(h));
    chk("fwd_b", fwd_b, f);
  endtask

  task automatic commit();
    logic acc;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < DEPTH) && (in_rd != 0);
      if (mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        e.rd = in_rd;
        e.d  = in_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [4:0] rd,
                     input logic [31:0] d, input logic [4:0] qa,
                     input logic [4:0] qb);
    drive(r, v, rd, d, qa, qb);
    check_model();
    commit();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    qaddr_a = '0; qaddr_b = '0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 3, 4);
    check_model();
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_hit_a", 32'(hit_a), 32'd0);
    chk("rst_fwd_b", fwd_b, 32'd0);
    commit();

    // single push, latency one cycle
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0);
    drive(0, 0, 0, 0, 5, 0);
    check_model();
    chk("lat_wen", 32'(rf_wen), 32'd1);
    chk("lat_waddr", 32'(rf_waddr), 32'd5);
    chk("lat_wdata", rf_wdata, 32'hDEADBEEF);
    chk("lat_hit_a", 32'(hit_a), 32'd1);
    chk("lat_fwd_a", fwd_a, 32'hDEADBEEF);
    commit();
    drive(0, 0, 0, 0, 5, 0);
    check_model();
    chk("drain_wen", 32'(rf_wen), 32'd0);
    commit();

    // write to x0 is swallowed
    drive(0, 1, 0, 32'h1234, 0, 0);
    check_model();
    chk("x0_ready", 32'(in_ready), 32'd1);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check_model();
    chk("x0_wen", 32'(rf_wen), 32'd0);
    chk("x0_hit_a", 32'(hit_a), 32'd0);
    commit();

    // back-to-back pushes, in_valid held
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'(i + 1), 32'hA0 + 32'(i), 0, 0);
      check_model();
      chk("b2b_ready", 32'(in_ready), 32'd1);
      if (i > 0) chk("b2b_order", 32'(rf_waddr), 32'(i));
      commit();
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // same rd twice: youngest wins, incoming data invisible
    cyc(0, 1, 7, 32'h11, 7, 0);
    drive(0, 1, 7, 32'h22, 7, 0);
    check_model();
    chk("dup_hit1", 32'(hit_a), 32'd1);
    chk("dup_fwd1", fwd_a, 32'h11);
    commit();
    drive(0, 0, 0, 0, 7, 0);
    check_model();
    chk("dup_hit2", 32'(hit_a), 32'd1);
    chk("dup_fwd2", fwd_a, 32'h22);
    chk("dup_wdata", rf_wdata, 32'h22);
    commit();
    drive(0, 0, 0, 0, 7, 0);
    check_model();
    chk("dup_hit3", 32'(hit_a), 32'd0);
    chk("dup_fwd3", fwd_a, 32'd0);
    commit();

    // reset with pending entry and a push attempt
    cyc(0, 1, 3, 32'h33, 0, 0);
    cyc(0, 1, 9, 32'h99, 0, 0);
    drive(1, 1, 4, 32'h44, 0, 9);
    check_model();
    chk("rst_busy_ready", 32'(in_ready), 32'd0);
    commit();
    drive(0, 0, 0, 0, 4, 9);
    check_model();
    chk("post_rst_wen", 32'(rf_wen), 32'd0);
    chk("post_rst_hit_b", 32'(hit_b), 32'd0);
    chk("post_rst_hit_a", 32'(hit_a), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    commit();

    // random stream
    for (int n = 0; n < 10000; n++) begin
      cyc(($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)),
          $urandom(),
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
